cfg_reg_decoder: RTL
====================

# cfg_reg_decoder

Parametrised byte-stream configuration decoder sitting between the UART receiver and the image-processing pipeline (edge/threshold stages). Parses a stream of (address, data) word pairs, writes a bank of NREG configuration registers, executes command opcodes, and issues a delayed, re-armable `config_en` pulse. Malformed or stalled frames are dropped and flagged on `err`.

## Interface
- `DW`, 8: word width of `din`, of addresses and of each register.
- `NREG`, 4: number of configuration registers; addresses 0x02 .. 0x01+NREG; NREG ≤ 2^DW−2.
- `ARM_DELAY`, 10: cycles from accepted ARM command to the `config_en` pulse; ≥1.
- `TIMEOUT`, 1024: max idle cycles allowed between the address word and the data word; ≥2.
- `clk`  in  1  system clock; the single clock of the block.
- `rst`  in  1  asynchronous, active-high reset.
- `din`  in  DW  incoming word (address or data, by position in the frame).
- `din_vld`  in  1  `din` valid for exactly this cycle.
- `reg_out`  out  NREG*DW  flattened register bank; reg k at bits [k*DW +: DW].
- `wr_pulse`  out  1  one-cycle strobe, 1 cycle after any successful register write.
- `config_en`  out  1  one-cycle pulse, ARM_DELAY cycles after an accepted ARM.
- `err`  out  1  one-cycle strobe on a dropped frame.

## Operation
- FSM states: IDLE, WAIT_DATA.
- IDLE: `din_vld` → latch `din` as address, → WAIT_DATA, clear timeout counter.
- WAIT_DATA: `din_vld` → execute (addr, din), → IDLE. No `din_vld` for TIMEOUT cycles → drop frame, `err` pulse, → IDLE.
- Address 0x01 = command register; data 0x01 = ARM, 0x02 = CLEAR, any other data → `err`, nothing else.
- ARM: load arm timer with ARM_DELAY; ARM while pending restarts the timer (only one pulse emitted).
- CLEAR: all registers → 0, pending ARM cancelled, `wr_pulse` asserted.
- Address 0x02 .. 0x01+NREG: reg[addr−2] ← data, `wr_pulse`.
- Address 0x00 or > 0x01+NREG: `err`, no state change.
- Address compare uses full DW bits; no truncation or wrap.
- Registers hold value until overwritten, CLEAR, or `rst`.

## Timing
- Reset values: `reg_out` = 0, `wr_pulse` = 0, `config_en` = 0, `err` = 0, FSM = IDLE, arm timer idle.
- Register write: data word sampled at edge N; `reg_out` and `wr_pulse` updated at edge N (visible cycle N+1); `wr_pulse` low again at N+1.
- ARM accepted at edge N → `config_en` high for cycle after edge N+ARM_DELAY, exactly one cycle.
- Timeout: address at edge N, no further `din_vld` → `err` visible after edge N+TIMEOUT, FSM IDLE same edge; a `din_vld` on that same cycle is treated as a new address word.
- `din_vld` every cycle supported; back-to-back frames with no gap, full throughput.
- ARM and timer expiry on same cycle: expiry pulse is suppressed, timer restarts.
- CLEAR and timer expiry on same cycle: no `config_en`.
- `rst` mid-frame or mid-delay: abort immediately, all outputs to reset values, partial frame discarded.

## Structure
- Shared package `cfg_pkg`: CMD_ADDR = 0x01, REG_BASE = 0x02, OP_ARM = 0x01, OP_CLEAR = 0x02, FSM state enum.
- Sub-module `cfg_arm_timer`: load/cancel inputs, DELAY parameter, one-cycle `expire` output; instantiated once.
- Frame FSM, timeout counter, register bank and decode stay in the top.

## Test plan
- Reset then frames (0x02,0x5A), (0x05,0xC3) with NREG=4 → reg0 = 0x5A, reg3 = 0xC3, two `wr_pulse`, `err` never.
- (0x01,0x01) at edge N, ARM_DELAY=10 → single `config_en` after edge N+10; second ARM at N+5 → single pulse after N+15 only.
- Write regs, then (0x01,0x02) → `reg_out` = 0, pending ARM produces no `config_en`.
- (0x06,0x11) and (0x00,0x11) with NREG=4 → two `err` pulses, `reg_out` unchanged.
- Address 0x02 then idle TIMEOUT cycles → `err` at N+TIMEOUT; next pair (0x03,0x77) → reg1 = 0x77.
- `rst` asserted between address and data words → outputs 0; following (0x02,0x33) → reg0 = 0x33.

Source files
------------

// File: rtl/cfg_pkg.sv
// Shared constants and types for the configuration frame decoder.
package cfg_pkg;

  // Command register address and the first configuration register address.
  localparam int CMD_ADDR = 1;
  localparam int REG_BASE = 2;

  // Opcodes accepted as data on the command register.
  localparam int OP_ARM   = 1;
  localparam int OP_CLEAR = 2;

  // Frame parser position: expecting an address word or a data word.
  typedef enum logic {
    IDLE,
    WAIT_DATA
  } fsm_state_e;

endpackage

// File: rtl/cfg_reg_decoder_if.sv
// Incoming word stream: one word per cycle while din_vld is high.
interface cfg_reg_decoder_if #(
  parameter int DW = 8
);
  logic [DW-1:0] din;
  logic          din_vld;

  modport master (output din, output din_vld);
  modport slave  (input  din, input  din_vld);
endinterface

// File: rtl/cfg_arm_timer.sv
// Re-armable one-shot delay: `expire` pulses for one cycle DELAY cycles after
// the last `load`. A load on the expiry cycle restarts the count instead of
// pulsing; a cancel drops any pending expiry.
module cfg_arm_timer #(
  parameter int DELAY = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic cancel,
  output logic expire
);

  localparam int            CW       = $clog2(DELAY + 1);
  localparam logic [CW-1:0] LOAD_VAL = CW'(DELAY);
  localparam logic [CW-1:0] ONE      = CW'(1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          expire_q, expire_d;

  // Next count and expiry strobe; load wins over cancel and over expiry.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (which would infer a latch).
    cnt_d    = cnt_q;
    expire_d = 1'b0;
    if (load) begin
      cnt_d = LOAD_VAL;
    end else if (cancel) begin
      cnt_d = '0;
    end else if (cnt_q != '0) begin
      cnt_d    = cnt_q - ONE;
      expire_d = (cnt_q == ONE);
    end
  end

  // Count register and registered expiry pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      expire_q <= 1'b0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values regardless of statement order.
      cnt_q    <= cnt_d;
      expire_q <= expire_d;
    end
  end

  assign expire = expire_q;

endmodule

// File: rtl/cfg_reg_decoder.sv
// Configuration decoder: parses (address, data) word pairs from the byte
// stream, writes the register bank, executes ARM/CLEAR commands and drops
// frames whose data word does not arrive within TIMEOUT cycles.
module cfg_reg_decoder
  import cfg_pkg::*;
#(
  parameter int DW        = 8,
  parameter int NREG      = 4,
  parameter int ARM_DELAY = 10,
  parameter int TIMEOUT   = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  cfg_reg_decoder_if.slave     bus,
  output logic [NREG*DW-1:0]   reg_out,
  output logic                 wr_pulse,
  output logic                 config_en,
  output logic                 err
);

  localparam int            TW       = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TO_ONE   = TW'(1);
  localparam logic [DW-1:0] CMD_A    = DW'(CMD_ADDR);
  localparam logic [DW-1:0] ARM_OP   = DW'(OP_ARM);
  localparam logic [DW-1:0] CLEAR_OP = DW'(OP_CLEAR);

  fsm_state_e    state_q, state_d;
  logic [DW-1:0] addr_q, addr_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] reg_q [NREG];
  logic [DW-1:0] reg_d [NREG];
  logic          wr_pulse_q, wr_pulse_d;
  logic          err_q, err_d;
  logic          arm_load, arm_cancel;
  logic          reg_hit;

  // Frame FSM, timeout count and data-word decode/execute.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    reg_d      = reg_q;
    wr_pulse_d = 1'b0;
    err_d      = 1'b0;
    arm_load   = 1'b0;
    arm_cancel = 1'b0;
    reg_hit    = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.din_vld) begin
          addr_d  = bus.din;
          cnt_d   = '0;
          state_d = WAIT_DATA;
        end
      end

      WAIT_DATA: begin
        if (bus.din_vld) begin
          state_d = IDLE;
          if (addr_q == CMD_A) begin
            if (bus.din == ARM_OP) begin
              arm_load = 1'b1;
            end else if (bus.din == CLEAR_OP) begin
              arm_cancel = 1'b1;
              wr_pulse_d = 1'b1;
              for (int k = 0; k < NREG; k++) reg_d[k] = '0;
            end else begin
              err_d = 1'b1;
            end
          end else begin
            // Full-width compare against each register address; anything
            // else (0x00 or beyond the bank) is rejected.
            for (int k = 0; k < NREG; k++) begin
              if (addr_q == DW'(REG_BASE + k)) begin
                reg_d[k] = bus.din;
                reg_hit  = 1'b1;
              end
            end
            wr_pulse_d = reg_hit;
            err_d      = !reg_hit;
          end
        end else if (cnt_q == TO_LAST) begin
          // Data word overdue: drop the frame and look for a new address.
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + TO_ONE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State, address latch, timeout count, register bank and strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      cnt_q      <= '0;
      wr_pulse_q <= 1'b0;
      err_q      <= 1'b0;
      // NOTE: the register bank is plain flops and must read zero after reset, so it is reset explicitly here (a RAM-style array would not be).
      for (int k = 0; k < NREG; k++) reg_q[k] <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      wr_pulse_q <= wr_pulse_d;
      err_q      <= err_d;
      reg_q      <= reg_d;
    end
  end

  cfg_arm_timer #(
    .DELAY (ARM_DELAY)
  ) u_arm_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (arm_load),
    .cancel (arm_cancel),
    .expire (config_en)
  );

  for (genvar k = 0; k < NREG; k++) begin : g_reg_out
    assign reg_out[k*DW +: DW] = reg_q[k];
  end

  assign wr_pulse = wr_pulse_q;
  assign err      = err_q;

endmodule
